// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the response-owner encoding, the default data-memory base address,
// the default widths/limits, and the width of the starvation/lock counters.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_MEM_AW       = 11;
    localparam logic [31:0] DEF_DMEM_BASE    = 32'h1001_0000;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_LOCK_MAX     = 8;

    // Wide enough for the 1..15 range allowed for both limits.
    localparam int unsigned CNT_W = 4;

    // Which master the response registered last cycle belongs to.
    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCpu  = 2'd1,
        OwnDma  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the memory.
// Modports:
//   slave  - the arbiter side: takes CPU/DMA requests and memory read data,
//            drives stall/grant, responses and the memory port.
//   master - the environment side (CPU, DMA engine and memory model).
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW = DEF_MEM_AW
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              dma_err;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_addr_xlate.sv
// Byte address to data-memory word address translation (combinational).
// Ports:
//   addr_i      - byte address from a master
//   in_range_o  - address falls inside the data memory window
//   word_addr_o - memory word address (valid when in_range_o)
module dmem_addr_xlate
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW    = DEF_MEM_AW,
    parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE
) (
    input  logic [31:0]       addr_i,
    output logic              in_range_o,
    output logic [MEM_AW-1:0] word_addr_o
);

    logic [31:0] off;

    // Addresses below the base wrap to a huge offset and fail the check.
    assign off         = addr_i - DMEM_BASE;
    assign in_range_o  = off < (32'd4 << MEM_AW);
    assign word_addr_o = off[MEM_AW+1:2];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port.
// CPU has fixed priority; a saturating starvation counter and a bounded DMA
// burst lock guarantee progress for both masters. Read data returns to the
// master registered as owner, one cycle after the access.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   bus         - CPU/DMA request and response signals plus the memory port
//   cpu_stall_cycles, dma_wait_cycles - wrapping event counters, present only
//                 when DMEM_ARB_STATS_EN is defined
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW       = DEF_MEM_AW,
    parameter logic [31:0] DMEM_BASE    = DEF_DMEM_BASE,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned LOCK_MAX     = DEF_LOCK_MAX
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] cpu_stall_cycles,
    output logic [31:0] dma_wait_cycles,
`endif
    dmem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_MAX);

    logic              cpu_in_range, dma_in_range;
    logic [MEM_AW-1:0] cpu_word, dma_word;
    logic              cpu_act, cpu_win, dma_win, lock_win, starve_win;

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    owner_e            owner_q, owner_d;
    logic              rd_q, rd_d;
    logic              err_q, err_d;
    logic              cpu_rvalid, dma_rvalid;

    dmem_addr_xlate #(.MEM_AW(MEM_AW), .DMEM_BASE(DMEM_BASE)) u_cpu_xlate (
        .addr_i      (bus.cpu_addr),
        .in_range_o  (cpu_in_range),
        .word_addr_o (cpu_word)
    );

    dmem_addr_xlate #(.MEM_AW(MEM_AW), .DMEM_BASE(DMEM_BASE)) u_dma_xlate (
        .addr_i      (bus.dma_addr),
        .in_range_o  (dma_in_range),
        .word_addr_o (dma_word)
    );

    // Grant. An out-of-range CPU request does not take part: it is never
    // stalled, never blocks the DMA and gets no response. Nothing wins while
    // reset is high so no memory write can slip through.
    always_comb begin
        cpu_act    = bus.cpu_req & cpu_in_range;
        lock_win   = (lock_cnt_q != '0) && (lock_cnt_q < LOCK_LIM) && bus.dma_req;
        starve_win = (starve_cnt_q == STARVE_LIM) && bus.dma_req;
        cpu_win    = 1'b0;
        dma_win    = 1'b0;
        if (!reset) begin
            if (lock_win || starve_win) begin
                dma_win = 1'b1;
            end else if (cpu_act) begin
                cpu_win = 1'b1;
            end else if (bus.dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    always_comb begin
        owner_d      = OwnNone;
        rd_d         = 1'b0;
        err_d        = 1'b0;
        starve_cnt_d = '0;
        lock_cnt_d   = lock_cnt_q;

        if (cpu_win) begin
            owner_d = OwnCpu;
            rd_d    = ~bus.cpu_we;
        end else if (dma_win) begin
            owner_d = OwnDma;
            rd_d    = ~bus.dma_we;
            err_d   = ~dma_in_range;
        end

        if (bus.dma_req && cpu_win) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end

        // A locked win at the limit can only happen when the CPU was idle;
        // it then opens a fresh burst instead of extending the old one.
        if (!bus.dma_req || !bus.dma_lock) begin
            lock_cnt_d = '0;
        end else if (dma_win) begin
            lock_cnt_d = (lock_cnt_q == LOCK_LIM) ? CNT_W'(1) : lock_cnt_q + 1'b1;
        end else if (lock_cnt_q == LOCK_LIM) begin
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            owner_q      <= OwnNone;
            rd_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            owner_q      <= owner_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
        end
    end

    assign bus.cpu_stall = cpu_act & ~cpu_win;
    assign bus.dma_gnt   = dma_win;

    assign bus.mem_en    = cpu_win | (dma_win & dma_in_range);
    assign bus.mem_we    = cpu_win ? bus.cpu_we : (dma_win & dma_in_range & bus.dma_we);
    assign bus.mem_addr  = cpu_win ? cpu_word : dma_word;
    assign bus.mem_wdata = cpu_win ? bus.cpu_wdata : bus.dma_wdata;

    // Responses follow the registered owner, never the current winner.
    assign cpu_rvalid     = (owner_q == OwnCpu) && rd_q;
    assign dma_rvalid     = (owner_q == OwnDma) && (rd_q || err_q);
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.dma_err    = (owner_q == OwnDma) && err_q;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.dma_rdata  = (dma_rvalid && !err_q) ? bus.mem_rdata : 32'd0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q, wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (bus.cpu_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.dma_req && !dma_win) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign cpu_stall_cycles = stall_cnt_q;
    assign dma_wait_cycles  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run checked against a cycle-level reference model and a reference memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned AW     = 11;
    localparam int unsigned STARVE = 4;
    localparam int unsigned LOCKM  = 8;
    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam int unsigned WORDS  = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.MEM_AW(AW)) mif ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] cpu_stall_cycles, dma_wait_cycles;
`endif

    dmem_arbiter #(
        .MEM_AW       (AW),
        .DMEM_BASE    (BASE),
        .STARVE_LIMIT (STARVE),
        .LOCK_MAX     (LOCKM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef DMEM_ARB_STATS_EN
        .cpu_stall_cycles (cpu_stall_cycles),
        .dma_wait_cycles  (dma_wait_cycles),
`endif
        .bus              (mif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory seen by the DUT, and the bench's own reference copy.
    logic [31:0] fmem    [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];

    always @(posedge clk) begin
        if (mif.mem_en) begin
            if (mif.mem_we) fmem[mif.mem_addr] <= mif.mem_wdata;
            mif.mem_rdata <= fmem[mif.mem_addr];
        end
    end

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 * WORDS);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a - BASE) >> 2) % WORDS;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) return BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 15));
        if (r == 1) return BASE - 32'd4;
        if (r == 2) return BASE + 32'(4 * (WORDS - 1));
        return BASE + 32'(4 * $urandom_range(0, 15));
    endfunction

    // ---------------- reference model ----------------
    int          m_starve, m_lock, m_win;   // m_win: 0 none, 1 cpu, 2 dma
    bit          m_rsp_cpu, m_rsp_dma, m_rsp_err;
    logic [31:0] m_rsp_data;
    bit          e_stall, e_gnt, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wdata;
    int unsigned m_stall_cnt, m_wait_cnt;

    task automatic model_clear();
        m_starve = 0; m_lock = 0; m_win = 0;
        m_rsp_cpu = 0; m_rsp_dma = 0; m_rsp_err = 0; m_rsp_data = '0;
        m_stall_cnt = 0; m_wait_cnt = 0;
    endtask

    task automatic model_eval();
        bit cpu_act;
        cpu_act = mif.cpu_req && in_rng(mif.cpu_addr);
        if (reset) m_win = 0;
        else if (m_lock >= 1 && m_lock < LOCKM && mif.dma_req) m_win = 2;
        else if (m_starve == STARVE && mif.dma_req) m_win = 2;
        else if (cpu_act) m_win = 1;
        else if (mif.dma_req) m_win = 2;
        else m_win = 0;
        e_stall = cpu_act && (m_win != 1);
        e_gnt   = (m_win == 2);
        e_en    = (m_win == 1) || (m_win == 2 && in_rng(mif.dma_addr));
        e_we    = e_en && ((m_win == 1) ? mif.cpu_we : mif.dma_we);
        e_addr  = AW'(widx((m_win == 1) ? mif.cpu_addr : mif.dma_addr));
        e_wdata = (m_win == 1) ? mif.cpu_wdata : mif.dma_wdata;
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
        end else begin
            if (e_stall) m_stall_cnt++;
            if (mif.dma_req && !e_gnt) m_wait_cnt++;
            m_rsp_cpu = (m_win == 1) && !mif.cpu_we;
            m_rsp_err = (m_win == 2) && !in_rng(mif.dma_addr);
            m_rsp_dma = (m_win == 2) && (!mif.dma_we || m_rsp_err);
            if (e_en && !e_we) m_rsp_data = ref_mem[e_addr];
            if (e_en && e_we) ref_mem[e_addr] = e_wdata;
            if (mif.dma_req && m_win == 1) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
            else m_starve = 0;
            if (!mif.dma_req || !mif.dma_lock) m_lock = 0;
            else if (m_win == 2) m_lock = (m_lock == LOCKM) ? 1 : m_lock + 1;
            else if (m_lock == LOCKM) m_lock = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mif.cpu_req = 0; mif.cpu_we = 0; mif.cpu_addr = BASE; mif.cpu_wdata = '0;
        mif.dma_req = 0; mif.dma_we = 0; mif.dma_addr = BASE; mif.dma_wdata = '0;
        mif.dma_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        set_idle();
        tick();
        tick();
        reset = 0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++; if (mif.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset cpu_rvalid got=%b exp=0", mif.cpu_rvalid); end
        n_tests++; if (mif.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset dma_rvalid got=%b exp=0", mif.dma_rvalid); end
        n_tests++; if (mif.dma_err !== 1'b0) begin n_fail++; $display("FAIL reset dma_err got=%b exp=0", mif.dma_err); end
        n_tests++; if (mif.cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL reset cpu_rdata got=%h exp=0", mif.cpu_rdata); end
        n_tests++; if (mif.dma_rdata !== 32'd0) begin n_fail++; $display("FAIL reset dma_rdata got=%h exp=0", mif.dma_rdata); end
        n_tests++; if (mif.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset mem_en got=%b exp=0", mif.mem_en); end
    endtask

    task automatic test_cpu_only();
        do_reset();
        mif.cpu_req = 1; mif.cpu_addr = 32'h1001_0008;
        #1;
        n_tests++; if (mif.mem_en !== 1'b1) begin n_fail++; $display("FAIL cpu_only mem_en got=%b exp=1", mif.mem_en); end
        n_tests++; if (mif.mem_addr !== 11'd2) begin n_fail++; $display("FAIL cpu_only mem_addr got=%0d exp=2", mif.mem_addr); end
        n_tests++; if (mif.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_only cpu_stall got=%b exp=0", mif.cpu_stall); end
        tick();
        set_idle();
        #1;
        n_tests++; if (mif.cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL cpu_only cpu_rvalid got=%b exp=1", mif.cpu_rvalid); end
        n_tests++; if (mif.cpu_rdata !== init_word(2)) begin n_fail++; $display("FAIL cpu_only cpu_rdata got=%h exp=%h", mif.cpu_rdata, init_word(2)); end
        tick();
        n_tests++; if (mif.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_only rvalid_drop got=%b exp=0", mif.cpu_rvalid); end
    endtask

    task automatic test_contention();
        do_reset();
        mif.cpu_req = 1; mif.cpu_addr = BASE + 32'd12;
        mif.dma_req = 1; mif.dma_addr = BASE + 32'd16;
        for (int i = 0; i < 10; i++) begin
            bit exp_dma;
            exp_dma = (i % 5 == 4);
            #1;
            n_tests++; if (mif.dma_gnt !== exp_dma) begin n_fail++; $display("FAIL contention dma_gnt cyc=%0d got=%b exp=%b", i, mif.dma_gnt, exp_dma); end
            n_tests++; if (mif.cpu_stall !== exp_dma) begin n_fail++; $display("FAIL contention cpu_stall cyc=%0d got=%b exp=%b", i, mif.cpu_stall, exp_dma); end
            n_tests++; if (mif.mem_addr !== (exp_dma ? 11'd4 : 11'd3)) begin n_fail++; $display("FAIL contention mem_addr cyc=%0d got=%0d", i, mif.mem_addr); end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_lock_burst();
        do_reset();
        mif.cpu_req = 1; mif.cpu_addr = BASE;
        mif.dma_req = 1; mif.dma_addr = BASE + 32'd4; mif.dma_lock = 1;
        // 4 CPU wins build starvation, then 8 locked DMA beats, then the CPU.
        for (int i = 0; i < 13; i++) begin
            bit exp_dma;
            exp_dma = (i >= 4) && (i <= 11);
            #1;
            n_tests++; if (mif.dma_gnt !== exp_dma) begin n_fail++; $display("FAIL lock dma_gnt cyc=%0d got=%b exp=%b", i, mif.dma_gnt, exp_dma); end
            n_tests++; if (mif.cpu_stall !== exp_dma) begin n_fail++; $display("FAIL lock cpu_stall cyc=%0d got=%b exp=%b", i, mif.cpu_stall, exp_dma); end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_out_of_range();
        do_reset();
        mif.dma_req = 1; mif.dma_addr = 32'h1002_0000;
        #1;
        n_tests++; if (mif.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL oor dma_gnt got=%b exp=1", mif.dma_gnt); end
        n_tests++; if (mif.mem_en !== 1'b0) begin n_fail++; $display("FAIL oor mem_en got=%b exp=0", mif.mem_en); end
        tick();
        mif.dma_we = 1; mif.dma_addr = BASE - 32'd4;
        #1;
        n_tests++; if (mif.dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor dma_rvalid got=%b exp=1", mif.dma_rvalid); end
        n_tests++; if (mif.dma_err !== 1'b1) begin n_fail++; $display("FAIL oor dma_err got=%b exp=1", mif.dma_err); end
        n_tests++; if (mif.dma_rdata !== 32'd0) begin n_fail++; $display("FAIL oor dma_rdata got=%h exp=0", mif.dma_rdata); end
        n_tests++; if (mif.mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_wr mem_en got=%b exp=0", mif.mem_en); end
        tick();
        set_idle();
        mif.dma_req = 1; mif.dma_addr = BASE + 32'h1FFC;
        #1;
        n_tests++; if (mif.dma_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr dma_err got=%b exp=1", mif.dma_err); end
        n_tests++; if (mif.mem_en !== 1'b1 || mif.mem_addr !== 11'd2047) begin n_fail++; $display("FAIL top_word en=%b addr=%0d exp en=1 addr=2047", mif.mem_en, mif.mem_addr); end
        tick();
        set_idle();
        mif.cpu_req = 1; mif.cpu_addr = BASE + 32'h2000;
        #1;
        n_tests++; if (mif.dma_err !== 1'b0 || mif.dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL top_word rsp err=%b rvalid=%b exp 0/1", mif.dma_err, mif.dma_rvalid); end
        n_tests++; if (mif.cpu_stall !== 1'b0 || mif.mem_en !== 1'b0) begin n_fail++; $display("FAIL cpu_oor stall=%b en=%b exp 0/0", mif.cpu_stall, mif.mem_en); end
        tick();
        set_idle();
        #1;
        n_tests++; if (mif.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_oor cpu_rvalid got=%b exp=0", mif.cpu_rvalid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mif.dma_req = 1; mif.dma_addr = BASE + 32'd20;
        #1;
        n_tests++; if (mif.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b dma_gnt got=%b exp=1", mif.dma_gnt); end
        tick();
        set_idle();
        mif.cpu_req = 1; mif.cpu_addr = BASE + 32'd36;
        #1;
        n_tests++; if (mif.dma_rvalid !== 1'b1 || mif.dma_rdata !== init_word(5)) begin n_fail++; $display("FAIL b2b dma_rsp rvalid=%b data=%h exp 1/%h", mif.dma_rvalid, mif.dma_rdata, init_word(5)); end
        n_tests++; if (mif.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b cpu_early got=%b exp=0", mif.cpu_rvalid); end
        tick();
        set_idle();
        #1;
        n_tests++; if (mif.cpu_rvalid !== 1'b1 || mif.cpu_rdata !== init_word(9)) begin n_fail++; $display("FAIL b2b cpu_rsp rvalid=%b data=%h exp 1/%h", mif.cpu_rvalid, mif.cpu_rdata, init_word(9)); end
        n_tests++; if (mif.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b dma_cross got=%b exp=0", mif.dma_rvalid); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mif.cpu_req = 1; mif.cpu_addr = BASE;
        mif.dma_req = 1; mif.dma_addr = BASE + 32'd4; mif.dma_lock = 1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        n_tests++; if (mif.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid setup dma_gnt got=%b exp=1", mif.dma_gnt); end
        tick();
        reset = 1; mif.cpu_we = 1; mif.dma_we = 1;
        #1;
        n_tests++; if (mif.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid mem_en got=%b exp=0", mif.mem_en); end
        tick();
        reset = 0; mif.cpu_we = 0; mif.dma_we = 0;
        #1;
        n_tests++; if (mif.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid dma_rvalid got=%b exp=0", mif.dma_rvalid); end
        // Cleared lock and starvation: CPU owns the first four cycles again.
        for (int i = 0; i < 5; i++) begin
            bit exp_dma;
            exp_dma = (i == 4);
            n_tests++; if (mif.cpu_stall !== exp_dma) begin n_fail++; $display("FAIL rst_mid cpu_stall cyc=%0d got=%b exp=%b", i, mif.cpu_stall, exp_dma); end
            tick();
            #1;
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset         = ($urandom_range(0, 63) == 0);
            mif.cpu_req   = ($urandom_range(0, 99) < 65);
            mif.cpu_we    = ($urandom_range(0, 99) < 30);
            mif.cpu_addr  = rnd_addr();
            mif.cpu_wdata = $urandom();
            mif.dma_req   = ($urandom_range(0, 99) < 65);
            mif.dma_we    = ($urandom_range(0, 99) < 30);
            mif.dma_addr  = rnd_addr();
            mif.dma_wdata = $urandom();
            mif.dma_lock  = ($urandom_range(0, 99) < 75);
            #1;
            model_eval();
            n_tests++; if (mif.cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd cpu_stall cyc=%0d got=%b exp=%b", cyc, mif.cpu_stall, e_stall); end
            n_tests++; if (mif.dma_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd dma_gnt cyc=%0d got=%b exp=%b", cyc, mif.dma_gnt, e_gnt); end
            n_tests++; if (mif.mem_en !== e_en) begin n_fail++; $display("FAIL rnd mem_en cyc=%0d got=%b exp=%b", cyc, mif.mem_en, e_en); end
            n_tests++; if (mif.mem_we !== e_we) begin n_fail++; $display("FAIL rnd mem_we cyc=%0d got=%b exp=%b", cyc, mif.mem_we, e_we); end
            if (e_en) begin
                n_tests++; if (mif.mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd mem_addr cyc=%0d got=%0d exp=%0d", cyc, mif.mem_addr, e_addr); end
            end
            if (e_we) begin
                n_tests++; if (mif.mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd mem_wdata cyc=%0d got=%h exp=%h", cyc, mif.mem_wdata, e_wdata); end
            end
            n_tests++; if (mif.cpu_rvalid !== m_rsp_cpu) begin n_fail++; $display("FAIL rnd cpu_rvalid cyc=%0d got=%b exp=%b", cyc, mif.cpu_rvalid, m_rsp_cpu); end
            n_tests++; if (mif.cpu_rdata !== (m_rsp_cpu ? m_rsp_data : 32'd0)) begin n_fail++; $display("FAIL rnd cpu_rdata cyc=%0d got=%h", cyc, mif.cpu_rdata); end
            n_tests++; if (mif.dma_rvalid !== m_rsp_dma) begin n_fail++; $display("FAIL rnd dma_rvalid cyc=%0d got=%b exp=%b", cyc, mif.dma_rvalid, m_rsp_dma); end
            n_tests++; if (mif.dma_err !== (m_rsp_dma && m_rsp_err)) begin n_fail++; $display("FAIL rnd dma_err cyc=%0d got=%b", cyc, mif.dma_err); end
            n_tests++; if (mif.dma_rdata !== ((m_rsp_dma && !m_rsp_err) ? m_rsp_data : 32'd0)) begin n_fail++; $display("FAIL rnd dma_rdata cyc=%0d got=%h", cyc, mif.dma_rdata); end
`ifdef DMEM_ARB_STATS_EN
            n_tests++; if (cpu_stall_cycles !== m_stall_cnt) begin n_fail++; $display("FAIL rnd cpu_stall_cycles got=%0d exp=%0d", cpu_stall_cycles, m_stall_cnt); end
            n_tests++; if (dma_wait_cycles !== m_wait_cnt) begin n_fail++; $display("FAIL rnd dma_wait_cycles got=%0d exp=%0d", dma_wait_cycles, m_wait_cnt); end
`endif
            model_step();
            tick();
        end
        reset = 0;
        set_idle();
        tick();
    endtask

    initial begin
        reset = 1;
        set_idle();
        for (int i = 0; i < WORDS; i++) begin
            fmem[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        test_reset();
        test_cpu_only();
        test_contention();
        test_lock_burst();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
